// File: rtl/shift_sched_pkg.sv
// shift_sched_pkg: shared types and constants for the shift scheduler.
// Holds the FSM state enum, shift-unit opcodes and the default count width.
package shift_sched_pkg;

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  localparam logic [1:0] SH_HOLD  = 2'b00;
  localparam logic [1:0] SH_RIGHT = 2'b10;
  localparam logic [1:0] SH_LEFT  = 2'b01;
  localparam logic [1:0] SH_LOAD  = 2'b11;

endpackage

// File: rtl/shift_sched_if.sv
// shift_sched_if: client request/grant/result bus plus shift-unit controls.
// master = clients and shift unit; slave = the scheduler.
interface shift_sched_if #(
  parameter int CNT_W = shift_sched_pkg::CNT_W
);
  logic             req0;
  logic             req1;
  logic             dir0;
  logic             dir1;
  logic             mode0;
  logic             mode1;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic [7:0]       din0;
  logic [7:0]       din1;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic [7:0]       rdata;
  logic             rcarry;
  logic             busy;
  logic [1:0]       sh_s;
  logic             sh_m;
  logic [7:0]       sh_d;
  logic [7:0]       sh_q;
  logic             sh_cn;

  modport slave (
    input  req0, req1, dir0, dir1,
    input  mode0, mode1, cnt0, cnt1,
    input  din0, din1,
    output gnt0, gnt1, done0, done1,
    output rdata, rcarry, busy,
    output sh_s, sh_m, sh_d,
    input  sh_q, sh_cn
  );

  modport master (
    output req0, req1, dir0, dir1,
    output mode0, mode1, cnt0, cnt1,
    output din0, din1,
    input  gnt0, gnt1, done0, done1,
    input  rdata, rcarry, busy,
    input  sh_s, sh_m, sh_d,
    output sh_q, sh_cn
  );

endinterface

// File: rtl/shift_sched_arb.sv
// shift_sched_arb: 2-way arbiter, in req[1:0]/advance, out one-hot gnt + id.
// Round-robin by default; SHIFT_SCHED_FIXED_PRIO_EN gives client 0 priority.
module shift_sched_arb (
`ifndef SHIFT_SCHED_FIXED_PRIO_EN
  input  logic       clk,
  input  logic       rst_n,
`endif
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       id
);

  logic pick1;

`ifdef SHIFT_SCHED_FIXED_PRIO_EN
  assign pick1 = req[1] & ~req[0];
`else
  logic last;

  // On contention the client that was not served last wins.
  assign pick1 = req[1] & (~req[0] | ~last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (advance) begin
      last <= pick1;
    end
  end
`endif

  assign gnt = {pick1, req[0] & ~pick1};
  assign id  = pick1;

endmodule

// File: rtl/shift_sched.sv
// shift_sched: arbitrates two clients onto the shared shift unit and sequences it.
// Ports: clk, rst_n (async low), bus (slave). Macro: SHIFT_SCHED_FIXED_PRIO_EN.
module shift_sched #(
  parameter int CNT_W = shift_sched_pkg::CNT_W
) (
  input logic        clk,
  input logic        rst_n,
  shift_sched_if.slave bus
);
  import shift_sched_pkg::*;

  state_t           st;
  state_t           st_n;
  logic             own;
  logic             l_dir;
  logic             l_mode;
  logic [CNT_W-1:0] l_cnt;
  logic [7:0]       l_din;
  logic [CNT_W-1:0] rem;
  logic [1:0]       rq;
  logic [1:0]       gnt;
  logic             win;
  logic             take;
  logic             done0_q;
  logic             done1_q;
  logic [7:0]       rdata_q;
  logic             rcarry_q;
  logic [1:0]       sh_s;

  assign rq   = {bus.req1, bus.req0} & {2{st == IDLE}};
  assign take = |gnt;

  shift_sched_arb u_arb (
`ifndef SHIFT_SCHED_FIXED_PRIO_EN
    .clk     (clk),
    .rst_n   (rst_n),
`endif
    .req     (rq),
    .advance (take),
    .gnt     (gnt),
    .id      (win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      own      <= 1'b0;
      l_dir    <= 1'b0;
      l_mode   <= 1'b0;
      l_cnt    <= '0;
      l_din    <= 8'h00;
      rem      <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata_q  <= 8'h00;
      rcarry_q <= 1'b0;
    end else begin
      st      <= st_n;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      if (take) begin
        own    <= win;
        l_dir  <= win ? bus.dir1 : bus.dir0;
        l_mode <= win ? bus.mode1 : bus.mode0;
        l_cnt  <= win ? bus.cnt1 : bus.cnt0;
        l_din  <= win ? bus.din1 : bus.din0;
      end
      if (st == LOAD) begin
        rem <= l_cnt;
      end else if (st == SHIFT) begin
        rem <= rem - CNT_W'(1);
      end
      if (st == DONE) begin
        rdata_q  <= bus.sh_q;
        rcarry_q <= (l_cnt == '0) ? 1'b0 : bus.sh_cn;
        done0_q  <= ~own;
        done1_q  <= own;
      end
    end
  end

  always_comb begin
    st_n = st;
    unique case (st)
      IDLE:  if (take) st_n = LOAD;
      LOAD:  st_n = (l_cnt != '0) ? SHIFT : DONE;
      SHIFT: if (rem == CNT_W'(1)) st_n = DONE;
      DONE:  st_n = IDLE;
    endcase
  end

  always_comb begin
    sh_s = SH_HOLD;
    unique case (1'b1)
      st == LOAD:  sh_s = SH_LOAD;
      st == SHIFT: sh_s = l_dir ? SH_LEFT : SH_RIGHT;
      default:     sh_s = SH_HOLD;
    endcase
  end

  assign bus.gnt0   = gnt[0];
  assign bus.gnt1   = gnt[1];
  assign bus.done0  = done0_q;
  assign bus.done1  = done1_q;
  assign bus.rdata  = rdata_q;
  assign bus.rcarry = rcarry_q;
  assign bus.busy   = st != IDLE;
  assign bus.sh_s   = sh_s;
  assign bus.sh_m   = l_mode;
  assign bus.sh_d   = (st == LOAD) ? l_din : 8'h00;

endmodule
